// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM burst tester.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_DATA = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // Right-shifting Galois form; 0xB400 gives a maximal-length 16-bit sequence.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] ERR_MAX   = 16'hFFFF;

endpackage

// File: rtl/sdram_burst_tester_if.sv
// User-side burst bus between the tester (master) and the SDRAM controller (slave).
interface sdram_burst_tester_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
);
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_length;
  logic [DATA_W-1:0] data_in;
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_length;
  logic [DATA_W-1:0] data_out;

  modport master (
    output wr_req, wr_addr, wr_length, data_in, rd_req, rd_addr, rd_length,
    input  wr_ack, rd_ack, data_out
  );

  modport slave (
    input  wr_req, wr_addr, wr_length, data_in, rd_req, rd_addr, rd_length,
    output wr_ack, rd_ack, data_out
  );
endinterface

// File: rtl/sdram_pattern_gen.sv
// Data pattern source: incrementing counter, or a Galois LFSR when
// SDRAM_TESTER_LFSR_EN is defined. seed wins over advance.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              seed,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] nxt;

`ifdef SDRAM_TESTER_LFSR_EN
  localparam logic [DATA_W-1:0] SEED_VAL = DATA_W'(LFSR_SEED);
  localparam logic [DATA_W-1:0] TAPS     = DATA_W'(LFSR_TAPS);

  always_comb begin
    nxt = word >> 1;
    if (word[0]) nxt = nxt ^ TAPS;
  end
`else
  localparam logic [DATA_W-1:0] SEED_VAL = '0;

  always_comb nxt = word + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n)     word <= '0;
    else if (seed)    word <= SEED_VAL;
    else if (advance) word <= nxt;
  end

endmodule

// File: rtl/sdram_burst_tester.sv
// Write-then-readback burst tester for the SDRAM controller user port.
// Pattern selection: define SDRAM_TESTER_LFSR_EN for LFSR data (see sdram_pattern_gen).
module sdram_burst_tester
  import sdram_test_pkg::*;
#(
  parameter int              ADDR_W     = 23,
  parameter int              DATA_W     = 16,
  parameter int              LEN_W      = 9,
  parameter int              BURST_LEN  = 8,
  parameter int              NUM_BURSTS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 init_done,
  sdram_burst_tester_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_err_addr
);

  localparam int BI_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1) + 1;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  word_cnt;
  logic [BI_W-1:0]   burst_idx;
  logic [WD_W-1:0]   wd_cnt;
  logic [ADDR_W-1:0] burst_addr;
  logic [DATA_W-1:0] wr_word, exp_word;
  logic wr_phase, rd_phase, wr_beat, rd_beat, beat;
  logic last_word, last_burst, accept, wd_expired, seed_exp;

  assign wr_phase   = (state == WR_REQ) || (state == WR_DATA);
  assign rd_phase   = (state == RD_REQ) || (state == RD_DATA);
  // Only the ack belonging to the current phase counts.
  assign wr_beat    = wr_phase && bus.wr_ack;
  assign rd_beat    = rd_phase && bus.rd_ack;
  assign beat       = wr_beat || rd_beat;
  assign last_word  = (word_cnt == LEN_W'(BURST_LEN - 1));
  assign last_burst = (burst_idx == BI_W'(NUM_BURSTS - 1));
  assign accept     = start && init_done && ((state == IDLE) || (state == FINISH));
  assign wd_expired = (wr_phase || rd_phase) && (wd_cnt == WD_W'(TIMEOUT)) && !beat;
  assign burst_addr = BASE_ADDR + ADDR_W'(burst_idx) * ADDR_W'(BURST_LEN);
  assign seed_exp   = accept || (wr_beat && last_word && last_burst);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH:     if (accept) state_nxt = WR_REQ;
      WR_REQ, WR_DATA:  if (wr_beat) state_nxt = !last_word ? WR_DATA :
                                                 (last_burst ? RD_REQ : WR_REQ);
      RD_REQ, RD_DATA:  if (rd_beat) state_nxt = !last_word ? RD_DATA :
                                                 (last_burst ? FINISH : RD_REQ);
      default:          state_nxt = IDLE;
    endcase
    if (wd_expired) state_nxt = FINISH;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_cnt       <= '0;
      burst_idx      <= '0;
      wd_cnt         <= '0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (state_nxt != state || beat) wd_cnt <= '0;
      else if (wr_phase || rd_phase)  wd_cnt <= wd_cnt + 1'b1;

      if (accept) begin
        word_cnt       <= '0;
        burst_idx      <= '0;
        timeout        <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end
      if (wd_expired) timeout <= 1'b1;

      if (beat) begin
        if (last_word) begin
          word_cnt  <= '0;
          burst_idx <= last_burst ? '0 : burst_idx + 1'b1;
        end else begin
          word_cnt  <= word_cnt + 1'b1;
        end
      end

      if (rd_beat && bus.data_out != exp_word) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        // err_count is cleared on start, so zero means this is the first miss.
        if (err_count == '0) first_err_addr <= burst_addr + ADDR_W'(word_cnt);
      end
    end
  end

  sdram_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (accept),
    .advance (wr_beat),
    .word    (wr_word)
  );

  sdram_pattern_gen #(.DATA_W(DATA_W)) u_exp_pat (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (seed_exp),
    .advance (rd_beat),
    .word    (exp_word)
  );

  assign busy          = wr_phase || rd_phase;
  assign done          = (state == FINISH);
  assign pass          = done && (err_count == '0) && !timeout;
  assign bus.wr_req    = (state == WR_REQ);
  assign bus.rd_req    = (state == RD_REQ);
  assign bus.wr_addr   = busy ? burst_addr : '0;
  assign bus.rd_addr   = busy ? burst_addr : '0;
  assign bus.wr_length = busy ? LEN_W'(BURST_LEN) : '0;
  assign bus.rd_length = busy ? LEN_W'(BURST_LEN) : '0;
  assign bus.data_in   = wr_word;

endmodule
